// File: rtl/if_ctrl_pkg.sv
// rtl/if_ctrl_pkg.sv - shared types and defaults for the pipeline sequencing controller
package if_ctrl_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } ctrlState_t;

  localparam int DEF_REG_ADDR_W  = 4;
  localparam int DEF_MEM_TIMEOUT = 15;
  localparam int DEF_CNT_W       = 4;
  localparam int DEF_PERF_W      = 16;

endpackage

// File: rtl/mem_wait_fsm.sv
// rtl/mem_wait_fsm.sv - tracks an outstanding SRAM access, freezes the pipeline, aborts on timeout
module mem_wait_fsm
  import if_ctrl_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic memReq,
  input  logic memReady,
  output logic memFreeze,
  output logic timeoutErr
);

  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  ctrlState_t       state, stateNext;
  logic [CNT_W-1:0] waitCnt, waitCntNext;
  logic             freezeRaw;
  logic             setTimeout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= RUN;
      waitCnt    <= '0;
      timeoutErr <= 1'b0;
    end else begin
      state   <= stateNext;
      waitCnt <= waitCntNext;
      if (setTimeout) timeoutErr <= 1'b1;
    end
  end

  always_comb begin
    stateNext   = state;
    waitCntNext = waitCnt;
    freezeRaw   = 1'b0;
    setTimeout  = 1'b0;
    case (state)
      RUN: begin
        // A request completing in the same cycle needs no wait at all
        if (memReq && !memReady) begin
          freezeRaw   = 1'b1;
          stateNext   = MEM_WAIT;
          waitCntNext = '0;
        end
      end
      MEM_WAIT: begin
        if (memReady) begin
          stateNext   = RUN;
          waitCntNext = '0;
        end else if (waitCnt == WAIT_LAST) begin
          stateNext   = RUN;
          waitCntNext = '0;
          setTimeout  = 1'b1;
        end else begin
          freezeRaw   = 1'b1;
          waitCntNext = waitCnt + 1'b1;
        end
      end
      default: stateNext = RUN;
    endcase
  end

  assign memFreeze = freezeRaw & ~rst;

endmodule

// File: rtl/if_pipeline_ctrl.sv
// rtl/if_pipeline_ctrl.sv - RAW stall, branch flush, MEM freeze and stall counter for the 5-stage core
// Build option IF_CTRL_FORWARDING_EN limits RAW stalls to EXE-stage load-use.
module if_pipeline_ctrl
  import if_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W  = DEF_REG_ADDR_W,
  parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int PERF_W      = DEF_PERF_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_src1,
  input  logic [REG_ADDR_W-1:0] id_src2,
  input  logic                  id_use_src1,
  input  logic                  id_two_src,
  input  logic [REG_ADDR_W-1:0] exe_dest,
  input  logic                  exe_wb_en,
  input  logic                  exe_mem_r_en,
  input  logic [REG_ADDR_W-1:0] mem_dest,
  input  logic                  mem_wb_en,
  input  logic                  branch_taken,
  input  logic                  mem_req,
  input  logic                  mem_ready,
  output logic                  hazard,
  output logic                  flush,
  output logic                  mem_freeze,
  output logic                  timeout_err,
  output logic [PERF_W-1:0]     stall_cnt
);

  localparam logic [PERF_W-1:0] STALL_MAX = '1;

  logic exeQual, memQual;
  logic src1Match, src2Match, rawMatch;
  logic memFreezeInt, flushInt, hazardInt;

  mem_wait_fsm #(
    .CNT_W      (CNT_W),
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) uMemWait (
    .clk       (clk),
    .rst       (rst),
    .memReq    (mem_req),
    .memReady  (mem_ready),
    .memFreeze (memFreezeInt),
    .timeoutErr(timeout_err)
  );

`ifdef IF_CTRL_FORWARDING_EN
  // Only a load in EXE cannot be forwarded in time; MEM results always can
  assign exeQual = exe_wb_en & exe_mem_r_en;
  assign memQual = 1'b0 & mem_wb_en;
`else
  // Without forwarding, loads and ALU results stall alike
  assign exeQual = exe_wb_en & (exe_mem_r_en | ~exe_mem_r_en);
  assign memQual = mem_wb_en;
`endif

  assign src1Match = id_use_src1 & ((exeQual & (id_src1 == exe_dest)) |
                                    (memQual & (id_src1 == mem_dest)));
  assign src2Match = id_two_src  & ((exeQual & (id_src2 == exe_dest)) |
                                    (memQual & (id_src2 == mem_dest)));
  assign rawMatch  = src1Match | src2Match;

  // EXE holds its branch through a freeze, so the flush lands on the first unfrozen cycle
  assign flushInt  = branch_taken & ~memFreezeInt & ~rst;
  assign hazardInt = rawMatch & ~flushInt & ~memFreezeInt & ~rst;

  assign mem_freeze = memFreezeInt;
  assign flush      = flushInt;
  assign hazard     = hazardInt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if ((hazardInt | memFreezeInt) && (stall_cnt != STALL_MAX)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule
